mio_bus_responder: RTL and testbench

//  Memory/IO responder for the single-cycle RISC-V core's data bus. Accepts CPU_MIO requests (MemRW selects

---
 rtl/mio_pkg.sv | 26 ++
 rtl/mio_addr_decode.sv | 19 +
 rtl/mio_bus_responder.sv | 135 +++++++++++++
 tb/tb_mio_bus_responder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mio_pkg.sv
// Shared encodings for the CPU data-bus responder: FSM states, address map and
// the decoded-region struct passed from the address decoder to the top.
package mio_pkg;

    localparam int DATA_W = 32;

    localparam logic [3:0]  RAM_NIBBLE = 4'h0;
    localparam logic [31:0] LED_ADDR   = 32'hF000_0000;
    localparam logic [31:0] SW_ADDR    = 32'hF000_0004;
    localparam logic [31:0] CNT_ADDR   = 32'hF000_0008;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef struct packed {
        logic is_ram;
        logic is_led;
        logic is_sw;
        logic is_cnt;
        logic is_unmapped;
    } dec_t;

endpackage

// File: rtl/mio_addr_decode.sv
// Combinational region decode of a word address (byte address bits [31:2]);
// exactly one flag in the returned struct is set.
module mio_addr_decode
    import mio_pkg::*;
(
    input  logic [31:2] word_addr,
    output dec_t        dec
);

    always_comb begin
        dec             = '0;
        dec.is_ram      = (word_addr[31:28] == RAM_NIBBLE);
        dec.is_led      = (word_addr == LED_ADDR[31:2]);
        dec.is_sw       = (word_addr == SW_ADDR[31:2]);
        dec.is_cnt      = (word_addr == CNT_ADDR[31:2]);
        dec.is_unmapped = !(dec.is_ram || dec.is_led || dec.is_sw || dec.is_cnt);
    end

endmodule

// File: rtl/mio_bus_responder.sv
// Memory/IO responder for the CPU data port: decodes each request to data RAM
// or a peripheral register, inserts RAM wait states, and pulses mio_ready.
module mio_bus_responder
    import mio_pkg::*;
#(
    parameter int RAM_WAIT = 1,
    parameter int RAM_AW   = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_mio,
    input  logic              mem_rw,
    input  logic [31:0]       addr,
    input  logic [31:0]       data_from_cpu,
    output logic [31:0]       data_to_cpu,
    output logic              mio_ready,
    output logic              bus_err,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_din,
    output logic              ram_we,
    input  logic [31:0]       ram_dout,
    input  logic [15:0]       sw_in,
    output logic [15:0]       led_out
);

    state_e      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic [31:2] addr_q, addr_d;
    logic        rw_q, rw_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [15:0] led_q, led_d;
    logic [31:0] cnt_q, cnt_d;
    logic [15:0] sw_meta_q, sw_sync_q;

    dec_t dec_req;
    dec_t dec_lat;

    // Byte-lane bits are not used: all accesses are whole words.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[1:0];

    mio_addr_decode u_dec_req (
        .word_addr (addr[31:2]),
        .dec       (dec_req)
    );

    mio_addr_decode u_dec_lat (
        .word_addr (addr_q),
        .dec       (dec_lat)
    );

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        led_d   = led_q;
        cnt_d   = cnt_q + 32'd1;
        ram_we  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cpu_mio) begin
                    addr_d  = addr[31:2];
                    rw_d    = mem_rw;
                    wdata_d = data_from_cpu;
                    wait_d  = dec_req.is_ram ? 8'(RAM_WAIT) : 8'd0;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (wait_q != 8'd0) begin
                    wait_d = wait_q - 8'd1;
                end else begin
                    state_d = ST_RESP;
                    if (rw_q) begin
                        ram_we = dec_lat.is_ram;
                        if (dec_lat.is_led) led_d = wdata_q[15:0];
                        // A CPU load of the counter overrides this cycle's increment.
                        if (dec_lat.is_cnt) cnt_d = wdata_q;
                    end else begin
                        if (dec_lat.is_ram)      rdata_d = ram_dout;
                        else if (dec_lat.is_led) rdata_d = {16'h0000, led_q};
                        else if (dec_lat.is_sw)  rdata_d = {16'h0000, sw_sync_q};
                        else if (dec_lat.is_cnt) rdata_d = cnt_q;
                        else                     rdata_d = 32'h0000_0000;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            wait_q    <= '0;
            addr_q    <= '0;
            rw_q      <= 1'b0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            led_q     <= '0;
            cnt_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            addr_q    <= addr_d;
            rw_q      <= rw_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            led_q     <= led_d;
            cnt_q     <= cnt_d;
            sw_meta_q <= sw_in;
            sw_sync_q <= sw_meta_q;
        end
    end

    assign mio_ready   = (state_q == ST_RESP);
    assign bus_err     = mio_ready && dec_lat.is_unmapped;
    assign data_to_cpu = rdata_q;
    assign ram_addr    = addr_q[RAM_AW+1:2];
    assign ram_din     = wdata_q;
    assign led_out     = led_q;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Directed bench for mio_bus_responder with a behavioural synchronous RAM.
module tb_mio_bus_responder;

    logic        clk;
    logic        rst_n;
    logic        cpu_mio;
    logic        mem_rw;
    logic [31:0] addr;
    logic [31:0] data_from_cpu;
    logic [31:0] data_to_cpu;
    logic        mio_ready;
    logic        bus_err;
    logic [9:0]  ram_addr;
    logic [31:0] ram_din;
    logic        ram_we;
    logic [31:0] ram_dout;
    logic [15:0] sw_in;
    logic [15:0] led_out;

    int n_checks;
    int n_fail;

    logic [31:0] mem [0:1023];

    mio_bus_responder #(.RAM_WAIT(1), .RAM_AW(10)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cpu_mio       (cpu_mio),
        .mem_rw        (mem_rw),
        .addr          (addr),
        .data_from_cpu (data_from_cpu),
        .data_to_cpu   (data_to_cpu),
        .mio_ready     (mio_ready),
        .bus_err       (bus_err),
        .ram_addr      (ram_addr),
        .ram_din       (ram_din),
        .ram_we        (ram_we),
        .ram_dout      (ram_dout),
        .sw_in         (sw_in),
        .led_out       (led_out)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous RAM, one-cycle read latency
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives one request from a negedge in IDLE; returns one negedge into the following IDLE.
    task automatic txn(input logic rw, input logic [31:0] a, input logic [31:0] d,
                       output int lat, output logic [31:0] rd, output logic berr,
                       output int we_cnt, output logic [9:0] we_addr);
        logic got;
        cpu_mio       = 1'b1;
        mem_rw        = rw;
        addr          = a;
        data_from_cpu = d;
        lat     = 0;
        we_cnt  = 0;
        we_addr = '0;
        got     = 1'b0;
        while (!got && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (ram_we) begin
                we_cnt++;
                we_addr = ram_addr;
            end
            if (mio_ready) got = 1'b1;
        end
        rd      = data_to_cpu;
        berr    = bus_err;
        cpu_mio = 1'b0;
        mem_rw  = 1'b0;
        if (!got) lat = -1;
        @(negedge clk);
    endtask

    int          lat;
    logic [31:0] rd;
    logic        berr;
    int          we_cnt;
    logic [9:0]  we_addr;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        ram_dout      = 32'h0;
        rst_n         = 1'b0;
        cpu_mio       = 1'b0;
        mem_rw        = 1'b0;
        addr          = 32'h0;
        data_from_cpu = 32'h0;
        sw_in         = 16'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check32("rst_ready",  {31'b0, mio_ready}, 32'h0);
        check32("rst_berr",   {31'b0, bus_err},   32'h0);
        check32("rst_rdata",  data_to_cpu,        32'h0);
        check32("rst_led",    {16'h0, led_out},   32'h0);
        check32("rst_ram_we", {31'b0, ram_we},    32'h0);
        check32("rst_ramadr", {22'h0, ram_addr},  32'h0);

        // RAM write then read
        txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, lat, rd, berr, we_cnt, we_addr);
        check32("ramw_lat",    lat,               32'd3);
        check32("ramw_we_cnt", we_cnt,            32'd1);
        check32("ramw_we_adr", {22'h0, we_addr},  32'd4);
        check32("ramw_berr",   {31'b0, berr},     32'h0);
        txn(1'b0, 32'h0000_0010, 32'h0, lat, rd, berr, we_cnt, we_addr);
        check32("ramr_lat",    lat,    32'd3);
        check32("ramr_data",   rd,     32'hDEAD_BEEF);
        check32("ramr_we_cnt", we_cnt, 32'd0);

        // LED register
        txn(1'b1, 32'hF000_0000, 32'h0001_A5A5, lat, rd, berr, we_cnt, we_addr);
        check32("ledw_lat", lat,              32'd2);
        check32("ledw_led", {16'h0, led_out}, 32'h0000_A5A5);
        txn(1'b0, 32'hF000_0000, 32'h0, lat, rd, berr, we_cnt, we_addr);
        check32("ledr_data", rd, 32'h0000_A5A5);

        // switches through the synchronizer; writes there are ignored
        sw_in = 16'h1234;
        repeat (3) @(negedge clk);
        txn(1'b0, 32'hF000_0004, 32'h0, lat, rd, berr, we_cnt, we_addr);
        check32("swr_lat",  lat, 32'd2);
        check32("swr_data", rd,  32'h0000_1234);
        txn(1'b1, 32'hF000_0004, 32'h0000_5555, lat, rd, berr, we_cnt, we_addr);
        check32("sww_led",  {16'h0, led_out}, 32'h0000_A5A5);
        check32("sww_berr", {31'b0, berr},    32'h0);

        // counter: load, then wrap through zero, then keep counting
        txn(1'b1, 32'hF000_0008, 32'hFFFF_FFFE, lat, rd, berr, we_cnt, we_addr);
        check32("cntw_we_cnt", we_cnt, 32'd0);
        txn(1'b0, 32'hF000_0008, 32'h0, lat, rd, berr, we_cnt, we_addr);
        check32("cnt_wrap", rd, 32'h0000_0000);
        txn(1'b0, 32'hF000_0008, 32'h0, lat, rd, berr, we_cnt, we_addr);
        check32("cnt_incr", rd, 32'h0000_0003);

        // unmapped address
        txn(1'b0, 32'h8000_0000, 32'h0, lat, rd, berr, we_cnt, we_addr);
        check32("unm_lat",    lat,           32'd2);
        check32("unm_berr",   {31'b0, berr}, 32'h1);
        check32("unm_data",   rd,            32'h0);
        check32("unm_we_cnt", we_cnt,        32'd0);

        // reset in the middle of a RAM write
        cpu_mio       = 1'b1;
        mem_rw        = 1'b1;
        addr          = 32'h0000_0020;
        data_from_cpu = 32'h1111_2222;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check32("arst_ready", {31'b0, mio_ready}, 32'h0);
        check32("arst_led",   {16'h0, led_out},   32'h0);
        check32("arst_we",    {31'b0, ram_we},    32'h0);
        cpu_mio = 1'b0;
        mem_rw  = 1'b0;
        @(negedge clk);
        check32("arst_ready2", {31'b0, mio_ready}, 32'h0);
        rst_n = 1'b1;
        txn(1'b0, 32'hF000_0008, 32'h0, lat, rd, berr, we_cnt, we_addr);
        check32("arst_cnt", rd, 32'h0000_0001);
        txn(1'b0, 32'h0000_0020, 32'h0, lat, rd, berr, we_cnt, we_addr);
        check32("arst_aborted", rd,  32'h0);
        check32("arst_lat",     lat, 32'd3);
        txn(1'b0, 32'h0000_0010, 32'h0, lat, rd, berr, we_cnt, we_addr);
        check32("arst_ramr", rd, 32'hDEAD_BEEF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
